// File: rtl/aes_encrypt_if.sv
// Request/response bundle for the iterative AES encryptor.
// Master issues requests; the encryptor core is the slave.
interface aes_encrypt_if #(
  parameter int Nk = 4
);
  logic              start;
  logic              key_load;
  logic [127:0]      data_in;
  logic [Nk*32-1:0]  key_in;
  logic              busy;
  logic              done;
  logic [127:0]      data_out;
  logic              key_valid;

  modport master (
    output start, key_load, data_in, key_in,
    input  busy, done, data_out, key_valid
  );

  modport slave (
    input  start, key_load, data_in, key_in,
    output busy, done, data_out, key_valid
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one round per cycle,
// key schedule expanded on chip one word per cycle.
module aes_encrypt_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input logic          clk,
  input logic          rst,
  aes_encrypt_if.slave bus
);
  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW + 1);
  localparam int RW = $clog2(Nr + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  state_t         state, state_nx;
  logic [31:0]    w [NW];
  logic [IW-1:0]  wi;
  logic [3:0]     km;
  logic [7:0]     rcon;
  logic [RW-1:0]  rnd;
  logic [127:0]   st;
  logic [127:0]   dout;
  logic           kv;
  logic [31:0]    temp, wnew;
  logic [IW-1:0]  rb;
  logic [127:0]   rk, nxt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254 by repeated squaring, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]),
            sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (mix)
        o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      else
        o[127-32*c -: 32] = {a0, a1, a2, a3};
    end
    return o;
  endfunction

  always_comb begin
    temp = w[wi - IW'(1)];
    if (km == 4'd0)
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
    else if (Nk == 8 && km == 4'd4)
      temp = sub_word(temp);
    wnew = w[wi - IW'(Nk)] ^ temp;
  end

  always_comb begin
    rb  = IW'(rnd) << 2;
    rk  = {w[rb], w[rb + IW'(1)], w[rb + IW'(2)], w[rb + IW'(3)]};
    nxt = (rnd == '0) ? st ^ rk
                      : enc_round(st, rnd != RW'(Nr)) ^ rk;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.start)
          state_nx = (bus.key_load || !kv) ? EXPAND : ROUND;
      EXPAND:
        if (wi == IW'(NW - 1)) state_nx = ROUND;
      ROUND:
        if (rnd == RW'(Nr)) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      dout  <= '0;
      kv    <= 1'b0;
      wi    <= '0;
      km    <= '0;
      rcon  <= 8'h01;
      rnd   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE:
          if (bus.start) begin
            st  <= bus.data_in;
            rnd <= '0;
            if (state_nx == EXPAND) begin
              kv   <= 1'b0;
              wi   <= IW'(Nk);
              km   <= '0;
              rcon <= 8'h01;
            end
          end
        EXPAND: begin
          wi <= wi + IW'(1);
          km <= (km == 4'(Nk - 1)) ? 4'd0 : km + 4'd1;
          if (km == 4'd0) rcon <= xt(rcon);
          if (wi == IW'(NW - 1)) kv <= 1'b1;
        end
        ROUND: begin
          rnd <= rnd + RW'(1);
          st  <= nxt;
          if (rnd == RW'(Nr)) dout <= nxt;
        end
        default: ;
      endcase
    end
  end

  // Schedule store needs no reset: key_valid gates its use.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.start && state_nx == EXPAND)
      for (int j = 0; j < Nk; j++)
        w[j] <= bus.key_in[Nk*32-1-32*j -: 32];
    else if (state == EXPAND)
      w[wi] <= wnew;
  end

  assign bus.busy      = (state == EXPAND) || (state == ROUND);
  assign bus.done      = (state == DONE);
  assign bus.data_out  = dout;
  assign bus.key_valid = kv;
endmodule
